// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: synchronises port A/B pads, detects pin-change
// and INT0 events, keeps the GIFR flag image and issues a single
// request/acknowledge handshake toward the core's interrupt sequencer.
module gpio_irq_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int INT0_BIT    = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] pa_pin,
   input  logic [DATA_WIDTH-1:0] pb_pin,
   input  logic [DATA_WIDTH-1:0] pcmsk0,
   input  logic [DATA_WIDTH-1:0] pcmsk1,
   input  logic [2:0]            gimsk,
   input  logic [1:0]            isc,
   input  logic [2:0]            gifr_w1c,
   output logic [DATA_WIDTH-1:0] pina,
   output logic [DATA_WIDTH-1:0] pinb,
   output logic [2:0]            gifr,
   output logic                  irq_req,
   output logic [1:0]            irq_vec,
   input  logic                  irq_ack
);

   // Detection is armed once the synchroniser and the previous-value copy
   // both hold real pad data; the counter saturates at that point.
   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int WARM_W   = $clog2(WARM_MAX + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;

   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_a_r, sync_b_r;
   logic [DATA_WIDTH-1:0] prev_a_r, prev_b_r;
   logic [WARM_W-1:0]     warm_r;
   logic                  warm_done_s;
   logic [2:0]            set_s, clr_s, gifr_next_s;
   logic                  int0_now_s, int0_was_s, int0_edge_s;
   logic                  ack_take_s;
   logic [2:0]            pend_s;
   state_t                state_r, state_next_s;
   logic                  req_next_s;
   logic [1:0]            vec_next_s;

   assign pina        = sync_a_r[SYNC_STAGES-1];
   assign pinb        = sync_b_r[SYNC_STAGES-1];
   assign warm_done_s = (warm_r == WARM_W'(WARM_MAX));
   assign int0_now_s  = pinb[INT0_BIT];
   assign int0_was_s  = prev_b_r[INT0_BIT];
   assign ack_take_s  = (state_r == REQ) && irq_ack;

   // Pad synchronisers and one-cycle-delayed copies for change detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a_r <= '0;
         sync_b_r <= '0;
         prev_a_r <= '0;
         prev_b_r <= '0;
      end else begin
         sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], pa_pin};
         sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], pb_pin};
         prev_a_r <= pina;
         prev_b_r <= pinb;
      end
   end

   // Saturating warm-up counter that keeps reset-time pin levels from
   // looking like changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         warm_r <= '0;
      end else if (!warm_done_s) begin
         warm_r <= warm_r + WARM_W'(1);
      end else begin
         warm_r <= warm_r;
      end
   end

   // Event detection, flag clear sources and per-source pending terms.
   always_comb begin
      int0_edge_s = 1'b0;
      case (isc)
         2'b01:   int0_edge_s = int0_now_s ^ int0_was_s;
         2'b10:   int0_edge_s = int0_was_s & ~int0_now_s;
         2'b11:   int0_edge_s = ~int0_was_s & int0_now_s;
         default: int0_edge_s = 1'b0;
      endcase

      set_s[0] = warm_done_s & int0_edge_s;
      set_s[1] = warm_done_s & (|((pina ^ prev_a_r) & pcmsk0));
      set_s[2] = warm_done_s & (|((pinb ^ prev_b_r) & pcmsk1));

      // Level-mode INT0 owns no flag, so an ack of vector 1 leaves INTF0 alone.
      clr_s[0] = gifr_w1c[0] | (ack_take_s && (irq_vec == 2'd1) && (isc != 2'b00));
      clr_s[1] = gifr_w1c[1] | (ack_take_s && (irq_vec == 2'd2));
      clr_s[2] = gifr_w1c[2] | (ack_take_s && (irq_vec == 2'd3));

      gifr_next_s = (gifr & ~clr_s) | set_s;

      pend_s[0] = gimsk[0] & ((isc == 2'b00) ? ~int0_now_s : gifr[0]);
      pend_s[1] = gimsk[1] & gifr[1];
      pend_s[2] = gimsk[2] & gifr[2];
   end

   // Flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gifr <= 3'b000;
      end else begin
         gifr <= gifr_next_s;
      end
   end

   // Handshake state, request and vector registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         irq_req <= 1'b0;
         irq_vec <= 2'd0;
      end else begin
         state_r <= state_next_s;
         irq_req <= req_next_s;
         irq_vec <= vec_next_s;
      end
   end

   // Next-state logic: request latched from IDLE, held in REQ, one GAP cycle after ack.
   always_comb begin
      state_next_s = state_r;
      req_next_s   = irq_req;
      vec_next_s   = irq_vec;
      case (state_r)
         IDLE: begin
            if (|pend_s) begin
               state_next_s = REQ;
               req_next_s   = 1'b1;
               if (pend_s[0]) begin
                  vec_next_s = 2'd1;
               end else if (pend_s[1]) begin
                  vec_next_s = 2'd2;
               end else begin
                  vec_next_s = 2'd3;
               end
            end else begin
               req_next_s = 1'b0;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_next_s = GAP;
               req_next_s   = 1'b0;
            end else begin
               req_next_s   = 1'b1;
            end
         end
         GAP: begin
            state_next_s = IDLE;
            req_next_s   = 1'b0;
         end
         default: begin
            state_next_s = IDLE;
            req_next_s   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: a rule-level reference model compared
// every cycle, plus hand-computed checks at key points of each scenario.
module tb_gpio_irq_ctrl;

   localparam int W    = 8;
   localparam int IB   = 2;
   localparam int SYNC = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] pa_pin = '0, pb_pin = '0, pcmsk0 = '0, pcmsk1 = '0;
   logic [2:0]   gimsk = 3'b000, gifr_w1c = 3'b000;
   logic [1:0]   isc = 2'b00;
   logic         irq_ack = 1'b0;
   logic [W-1:0] pina, pinb;
   logic [2:0]   gifr;
   logic         irq_req;
   logic [1:0]   irq_vec;

   int n_vec = 0;
   int n_bad = 0;

   gpio_irq_ctrl #(.DATA_WIDTH(W), .INT0_BIT(IB), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset(reset), .pa_pin(pa_pin), .pb_pin(pb_pin),
      .pcmsk0(pcmsk0), .pcmsk1(pcmsk1), .gimsk(gimsk), .isc(isc),
      .gifr_w1c(gifr_w1c), .pina(pina), .pinb(pinb), .gifr(gifr),
      .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // ha/hb[i] is the pad value sampled i edges ago (0 = latest edge).
   logic [W-1:0] ha [0:SYNC];
   logic [W-1:0] hb [0:SYNC];
   int           m_edges;
   logic [2:0]   m_gifr;
   int           m_phase;   // 0 waiting, 1 requesting, 2 spacing cycle
   logic [1:0]   m_vec;

   // Advance the model by one clock using the rules on pre-edge values.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= SYNC; i++) begin ha[i] = '0; hb[i] = '0; end
         m_edges = 0; m_gifr = 3'b000; m_phase = 0; m_vec = 2'd0;
      end else begin
         logic [W-1:0] a_now, a_old, b_now, b_old;
         logic armed, now0, was0;
         logic [2:0] setf, clrf;
         bit want0, want1, want2;
         a_now = ha[SYNC-1]; a_old = ha[SYNC];
         b_now = hb[SYNC-1]; b_old = hb[SYNC];
         armed = (m_edges >= SYNC + 1);
         now0 = b_now[IB]; was0 = b_old[IB];
         setf[1] = armed && (((a_now ^ a_old) & pcmsk0) != 0);
         setf[2] = armed && (((b_now ^ b_old) & pcmsk1) != 0);
         setf[0] = armed && ((isc == 2'd1 && now0 != was0) ||
                             (isc == 2'd2 && was0 && !now0) ||
                             (isc == 2'd3 && !was0 && now0));
         want0 = gimsk[0] && ((isc == 2'd0) ? !now0 : m_gifr[0]);
         want1 = gimsk[1] && m_gifr[1];
         want2 = gimsk[2] && m_gifr[2];
         clrf = gifr_w1c;
         if (m_phase == 1 && irq_ack) begin
            if (m_vec == 2'd1 && isc != 2'd0) clrf[0] = 1'b1;
            if (m_vec == 2'd2) clrf[1] = 1'b1;
            if (m_vec == 2'd3) clrf[2] = 1'b1;
         end
         if (m_phase == 0 && (want0 || want1 || want2)) begin
            m_vec = want0 ? 2'd1 : (want1 ? 2'd2 : 2'd3);
            m_phase = 1;
         end else if (m_phase == 1 && irq_ack) begin
            m_phase = 2;
         end else if (m_phase == 2) begin
            m_phase = 0;
         end
         m_gifr = (m_gifr & ~clrf) | setf;
         for (int i = SYNC; i > 0; i--) begin ha[i] = ha[i-1]; hb[i] = hb[i-1]; end
         ha[0] = pa_pin; hb[0] = pb_pin;
         if (m_edges < 1000) m_edges++;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (!reset) begin
         chk("pina", pina, ha[SYNC-1]);
         chk("pinb", pinb, hb[SYNC-1]);
         chk("gifr", {5'd0, gifr}, {5'd0, m_gifr});
         chk("irq_req", {7'd0, irq_req}, {7'd0, 1'(m_phase == 1)});
         if (m_phase == 1) chk("irq_vec", {6'd0, irq_vec}, {6'd0, m_vec});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!irq_req && k < 20) begin tick(1); k++; end
      chk("wait_req", {7'd0, irq_req}, 8'h01);
   endtask

   task automatic ack_once();
      irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
   endtask

   initial begin
      // Reset with pins high: no spurious events.
      pa_pin = 8'hFF; pcmsk0 = 8'hFF; gimsk = 3'b010;
      tick(2);
      chk("rst_gifr", {5'd0, gifr}, 8'h00);
      chk("rst_req", {7'd0, irq_req}, 8'h00);
      chk("rst_vec", {6'd0, irq_vec}, 8'h00);
      chk("rst_pina", pina, 8'h00);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("warm_gifr", {5'd0, gifr}, 8'h00);
         chk("warm_req", {7'd0, irq_req}, 8'h00);
      end
      chk("warm_pina", pina, 8'hFF);

      // Masked toggle: nothing happens.
      pcmsk0 = 8'h00; pa_pin = 8'hF7; tick(6);
      chk("mask0_gifr", {5'd0, gifr}, 8'h00);
      chk("mask0_req", {7'd0, irq_req}, 8'h00);

      // Bit 3 rises with mask 08: flag on third edge, request on fourth.
      pcmsk0 = 8'h08; pa_pin = 8'hFF;
      tick(2); chk("pc0_pre", {5'd0, gifr}, 8'h00);
      tick(1); chk("pc0_flag", {5'd0, gifr}, 8'h02);
      chk("pc0_noreq", {7'd0, irq_req}, 8'h00);
      tick(1); chk("pc0_req", {7'd0, irq_req}, 8'h01);
      chk("pc0_vec", {6'd0, irq_vec}, 8'h02);
      ack_once();
      chk("pc0_ackreq", {7'd0, irq_req}, 8'h00);
      chk("pc0_ackgifr", {5'd0, gifr}, 8'h00);
      tick(4);

      // INT0 falling edge and PCINT1 in the same cycle: INT0 first, then PCINT1.
      gimsk = 3'b000; isc = 2'b10; pb_pin = 8'h04; tick(5);
      pcmsk1 = 8'h01; gimsk = 3'b101; tick(1);
      pb_pin = 8'h01;
      tick(3); chk("pri_flags", {5'd0, gifr}, 8'h05);
      tick(1); chk("pri_vec1", {6'd0, irq_vec}, 8'h01);
      chk("pri_req1", {7'd0, irq_req}, 8'h01);
      ack_once();
      chk("pri_gap", {7'd0, irq_req}, 8'h00);
      chk("pri_left", {5'd0, gifr}, 8'h04);
      tick(1); chk("pri_idle", {7'd0, irq_req}, 8'h00);
      tick(1); chk("pri_vec3", {6'd0, irq_vec}, 8'h03);
      chk("pri_req3", {7'd0, irq_req}, 8'h01);
      ack_once();
      chk("pri_clr", {5'd0, gifr}, 8'h00);
      tick(3);

      // Level-mode INT0: re-raised while low; no flag used.
      gimsk = 3'b000; pcmsk1 = 8'h00; pb_pin = 8'h05; tick(5);
      isc = 2'b00; gimsk = 3'b001; tick(3);
      chk("lvl_idle", {7'd0, irq_req}, 8'h00);
      pb_pin = 8'h01;
      for (int r = 0; r < 3; r++) begin
         wait_req();
         chk("lvl_vec", {6'd0, irq_vec}, 8'h01);
         chk("lvl_noflag", {5'd0, gifr}, 8'h00);
         if (r == 2) pb_pin = 8'h05;
         ack_once();
         chk("lvl_gap", {7'd0, irq_req}, 8'h00);
      end
      for (int i = 0; i < 6; i++) begin
         tick(1); chk("lvl_stop", {7'd0, irq_req}, 8'h00);
      end

      // Write-1-to-clear against a simultaneous set, then alone.
      gimsk = 3'b000; isc = 2'b10; pcmsk0 = 8'h08;
      pa_pin = 8'hF7; tick(4);
      chk("w1c_flag", {5'd0, gifr}, 8'h02);
      pa_pin = 8'hFF; tick(2);
      gifr_w1c = 3'b010; tick(1); gifr_w1c = 3'b000;
      chk("w1c_setwins", {5'd0, gifr}, 8'h02);
      gifr_w1c = 3'b010; tick(1); gifr_w1c = 3'b000;
      chk("w1c_clear", {5'd0, gifr}, 8'h00);
      irq_ack = 1'b1; tick(1); irq_ack = 1'b0;   // ack while idle: ignored
      chk("ack_idle", {7'd0, irq_req}, 8'h00);

      // Request held after its flag is cleared by software.
      gimsk = 3'b010; pa_pin = 8'hF7; tick(4);
      chk("hold_req", {7'd0, irq_req}, 8'h01);
      gifr_w1c = 3'b010; tick(1); gifr_w1c = 3'b000;
      tick(2);
      chk("hold_gifr", {5'd0, gifr}, 8'h00);
      chk("hold_req2", {7'd0, irq_req}, 8'h01);
      chk("hold_vec", {6'd0, irq_vec}, 8'h02);
      ack_once();
      chk("hold_done", {7'd0, irq_req}, 8'h00);
      tick(3);

      // Reset in the middle of a request.
      pa_pin = 8'hFF; tick(4);
      chk("mid_req", {7'd0, irq_req}, 8'h01);
      #2 reset = 1'b1;
      #1 chk("mid_rst_req", {7'd0, irq_req}, 8'h00);
      chk("mid_rst_gifr", {5'd0, gifr}, 8'h00);
      tick(2); reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1); chk("post_rst", {4'd0, gifr, irq_req}, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
